// File: rtl/inference_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : inference_scheduler_if
//  Description : Signal bundle between a host, the inference scheduler and
//                the neural-network core it drives.
//                  host side   : in_valid/in_ready/in_data,
//                                out_valid/out_ready/out_data/out_class
//                  network side: net_start/net_inputs, net_done/net_outputs
//                  status      : timeout_error, error_clear, frame_count
//                modport master : the scheduler (drives handshake outputs)
//                modport slave  : host plus network environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface inference_scheduler_if #(
    parameter int NUM_INPUTS     = 10,
    parameter int NUM_OUTPUTS    = 10,
    parameter int INTEGER_WIDTH  = 16,
    parameter int FRACTION_WIDTH = 16
);
    localparam int c_class_width = $clog2(NUM_OUTPUTS);

    logic                                         in_valid;
    logic                                         in_ready;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] in_data     [NUM_INPUTS];
    logic                                         net_start;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] net_inputs  [NUM_INPUTS];
    logic                                         net_done;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] net_outputs [NUM_OUTPUTS];
    logic                                         out_valid;
    logic                                         out_ready;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] out_data    [NUM_OUTPUTS];
    logic [c_class_width-1:0]                     out_class;
    logic                                         timeout_error;
    logic                                         error_clear;
    logic [15:0]                                  frame_count;

    modport master (
        input  in_valid, in_data, net_done, net_outputs, out_ready, error_clear,
        output in_ready, net_start, net_inputs, out_valid, out_data, out_class,
               timeout_error, frame_count
    );

    modport slave (
        output in_valid, in_data, net_done, net_outputs, out_ready, error_clear,
        input  in_ready, net_start, net_inputs, out_valid, out_data, out_class,
               timeout_error, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/inference_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : inference_scheduler
//  Description : Accepts one input frame from the host, launches the network
//                with a one-cycle start pulse, waits (under a watchdog) for
//                the network outputs, scans them for the argmax one element
//                per cycle and presents the result until the consumer takes it.
//  Ports       : clock        - single clock, rising edge
//                reset        - synchronous, active-high
//                bus (master) - host/network/status bundle, see the interface
//  Revision    : 1.0 - initial release
// ============================================================================
module inference_scheduler #(
    parameter int NUM_INPUTS     = 10,
    parameter int NUM_OUTPUTS    = 10,   // must be >= 2
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int INTEGER_WIDTH  = 16,
    parameter int FRACTION_WIDTH = 16
) (
    input wire logic              clock,
    input wire logic              reset,
    inference_scheduler_if.master bus
);

    localparam int c_class_width = $clog2(NUM_OUTPUTS);
    localparam int c_cnt_width   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_class_width-1:0] c_last_idx     = c_class_width'(NUM_OUTPUTS - 1);
    localparam logic [c_class_width-1:0] c_first_scan   = c_class_width'(1);
    localparam logic [c_cnt_width-1:0]   c_timeout_last = c_cnt_width'(TIMEOUT_CYCLES - 1);

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] word_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_ARGMAX  = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    word_t                     r_net_inputs [NUM_INPUTS];
    word_t                     r_out_data   [NUM_OUTPUTS];
    word_t                     r_best_val;
    logic [c_class_width-1:0]  r_best_idx;
    logic [c_class_width-1:0]  r_scan_idx;
    logic [c_cnt_width-1:0]    r_wd_count;
    logic                      r_timeout;
    logic [15:0]               r_frame_count;

    logic                      w_accept;
    logic                      w_done;
    logic                      w_timeout_hit;
    logic                      w_release;
    logic                      w_in_ready;
    logic                      w_net_start;
    logic                      w_out_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        w_timeout_hit = 1'b0;
        w_release     = 1'b0;
        w_in_ready    = 1'b0;
        w_net_start   = 1'b0;
        w_out_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_net_start  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last watchdog cycle still counts.
                if (bus.net_done) begin
                    w_done       = 1'b1;
                    w_state_next = S_ARGMAX;
                end else if (r_wd_count == c_timeout_last) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            S_ARGMAX: begin
                if (r_scan_idx == c_last_idx) begin
                    w_state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: frame capture, watchdog, result latch and argmax scan
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_net_inputs[i] <= '0;
            end
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                r_out_data[i] <= '0;
            end
            r_best_val    <= '0;
            r_best_idx    <= '0;
            r_scan_idx    <= '0;
            r_wd_count    <= '0;
            r_timeout     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_accept) begin
                r_net_inputs <= bus.in_data;
            end

            if (r_state == S_START) begin
                r_wd_count <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd_count <= r_wd_count + 1'b1;
            end

            // Element 0 seeds the running best, so the scan starts at 1.
            if (w_done) begin
                r_out_data <= bus.net_outputs;
                r_best_val <= bus.net_outputs[0];
                r_best_idx <= '0;
                r_scan_idx <= c_first_scan;
            end else if (r_state == S_ARGMAX) begin
                // Strict compare keeps the lower index on ties.
                if (r_out_data[r_scan_idx] > r_best_val) begin
                    r_best_val <= r_out_data[r_scan_idx];
                    r_best_idx <= r_scan_idx;
                end
                r_scan_idx <= r_scan_idx + 1'b1;
            end

            // Setting has priority over a simultaneous clear.
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end else if (bus.error_clear) begin
                r_timeout <= 1'b0;
            end

            if (w_release) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready      = w_in_ready;
    assign bus.net_start     = w_net_start;
    assign bus.net_inputs    = r_net_inputs;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_class     = r_best_idx;
    assign bus.timeout_error = r_timeout;
    assign bus.frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_inference_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inference_scheduler
//  Description : Randomised self-checking bench for inference_scheduler.
//                A sequential reference walks each frame through its
//                expected cycle timeline and computes the argmax directly
//                from the outputs it handed to the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inference_scheduler;

    localparam int NI = 10;
    localparam int NO = 10;
    localparam int TO = 64;
    localparam int IW = 16;
    localparam int FW = 16;

    typedef logic signed [IW-1:-FW] word_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    int    model_count = 0;
    bit    model_terr  = 1'b0;
    word_t exp_in  [NI];
    word_t exp_out [NO];

    inference_scheduler_if #(
        .NUM_INPUTS     (NI),
        .NUM_OUTPUTS    (NO),
        .INTEGER_WIDTH  (IW),
        .FRACTION_WIDTH (FW)
    ) bus ();

    inference_scheduler #(
        .NUM_INPUTS     (NI),
        .NUM_OUTPUTS    (NO),
        .TIMEOUT_CYCLES (TO),
        .INTEGER_WIDTH  (IW),
        .FRACTION_WIDTH (FW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Largest value first, then the earliest position holding it.
    function automatic int ref_argmax();
        word_t m;
        m = exp_out[0];
        for (int i = 1; i < NO; i++) begin
            if (exp_out[i] > m) m = exp_out[i];
        end
        for (int i = 0; i < NO; i++) begin
            if (exp_out[i] == m) return i;
        end
        return 0;
    endfunction

    // kind 0: full random, 1: single 3.5 at index 7, 2: ties at 2 and 6
    // over negatives, 3: small integers (frequent ties)
    function automatic word_t gen_word(input int kind, input int idx);
        int v;
        case (kind)
            1: v = (idx == 7) ? 229376 : 0;
            2: v = (idx == 2 || idx == 6) ? (5 * 65536) : -int'($urandom_range(1, 100000));
            3: v = (int'($urandom_range(0, 6)) - 3) * 65536;
            default: v = int'($urandom());
        endcase
        return word_t'(v);
    endfunction

    task automatic scramble_outputs();
        for (int i = 0; i < NO; i++) bus.net_outputs[i] = word_t'($urandom());
    endtask

    task automatic do_frame(input int d, input int kind, input int hold);
        int clr;
        check("idle_in_ready", bus.in_ready, 1);
        for (int i = 0; i < NI; i++) begin
            exp_in[i]      = word_t'($urandom());
            bus.in_data[i] = exp_in[i];
        end
        bus.in_valid = 1'b1;
        tick();
        // Start cycle: one after the accept edge.
        bus.in_valid = 1'($urandom_range(0, 1));
        for (int i = 0; i < NI; i++) bus.in_data[i] = word_t'($urandom());
        check("start_pulse", bus.net_start, 1);
        check("start_in_ready", bus.in_ready, 0);
        for (int i = 0; i < NI; i++) check("net_inputs", bus.net_inputs[i], exp_in[i]);
        tick();
        if (d < TO) begin
            repeat (d) begin
                check("wait_start_low", bus.net_start, 0);
                check("wait_in_ready", bus.in_ready, 0);
                scramble_outputs();
                tick();
            end
            for (int i = 0; i < NO; i++) begin
                exp_out[i]         = gen_word(kind, i);
                bus.net_outputs[i] = exp_out[i];
            end
            bus.net_done = 1'b1;
            tick();
            bus.net_done = 1'b0;
            scramble_outputs();
            for (int k = 1; k < NO; k++) begin
                check("argmax_no_valid", bus.out_valid, 0);
                bus.net_done = 1'($urandom_range(0, 1));
                scramble_outputs();
                tick();
            end
            bus.net_done = 1'b0;
            check("present_valid", bus.out_valid, 1);
            check("present_class", bus.out_class, ref_argmax());
            check("present_in_ready", bus.in_ready, 0);
            check("present_timeout", bus.timeout_error, model_terr);
            for (int i = 0; i < NO; i++) check("out_data", bus.out_data[i], exp_out[i]);
            repeat (hold) begin
                int j;
                bus.in_valid = 1'b1;
                tick();
                j = int'($urandom_range(0, NO - 1));
                check("hold_valid", bus.out_valid, 1);
                check("hold_class", bus.out_class, ref_argmax());
                check("hold_data", bus.out_data[j], exp_out[j]);
                check("hold_no_start", bus.net_start, 0);
                check("hold_in_ready", bus.in_ready, 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            model_count   = (model_count + 1) & 16'hFFFF;
            check("frame_count", bus.frame_count, model_count);
            check("release_valid", bus.out_valid, 0);
            check("release_in_ready", bus.in_ready, 1);
        end else begin
            clr = int'($urandom_range(0, 1));
            bus.error_clear = 1'(clr);
            for (int k = 0; k < TO; k++) begin
                check("to_no_valid", bus.out_valid, 0);
                check("to_in_ready", bus.in_ready, 0);
                check("to_flag_wait", bus.timeout_error, (k > 0 && clr != 0) ? 1'b0 : model_terr);
                scramble_outputs();
                tick();
            end
            bus.in_valid = 1'b0;
            check("to_flag_set", bus.timeout_error, 1);
            check("to_idle_ready", bus.in_ready, 1);
            check("to_no_valid_end", bus.out_valid, 0);
            model_terr = 1'b1;
            if (clr == 0) begin
                tick();
                check("to_sticky", bus.timeout_error, 1);
                bus.error_clear = 1'b1;
            end
            tick();
            bus.error_clear = 1'b0;
            model_terr      = 1'b0;
            check("to_cleared", bus.timeout_error, 0);
            check("to_count_same", bus.frame_count, model_count);
        end
    endtask

    task automatic reset_in_argmax();
        bus.in_valid = 1'b1;
        for (int i = 0; i < NI; i++) bus.in_data[i] = word_t'($urandom());
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NO; i++) bus.net_outputs[i] = gen_word(1, i);
        bus.net_done = 1'b1;
        tick();
        bus.net_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_count = 0;
        model_terr  = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_out_class", bus.out_class, 0);
        check("rst_out_data", bus.out_data[7], 0);
        check("rst_net_inputs", bus.net_inputs[0], 0);
        repeat (NO + 2) begin
            tick();
            check("rst_stays_idle", bus.out_valid, 0);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.net_done    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.error_clear = 1'b0;
        for (int i = 0; i < NI; i++) bus.in_data[i] = '0;
        for (int i = 0; i < NO; i++) bus.net_outputs[i] = '0;

        @(negedge clock);
        repeat (3) tick();
        reset = 1'b0;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_net_start", bus.net_start, 0);
        check("reset_frame_count", bus.frame_count, 0);
        check("reset_timeout", bus.timeout_error, 0);
        check("reset_out_class", bus.out_class, 0);
        check("reset_net_inputs", bus.net_inputs[3], 0);
        check("reset_out_data", bus.out_data[5], 0);

        tick();
        do_frame(20, 1, 0);
        do_frame(5, 2, 0);
        do_frame(3, 0, 15);
        do_frame(TO - 1, 3, 1);
        do_frame(TO, 0, 0);
        do_frame(0, 0, 2);
        reset_in_argmax();

        force dut.r_frame_count = 16'hFFFF;
        tick();
        release dut.r_frame_count;
        model_count = 16'hFFFF;
        tick();
        check("preset_count", bus.frame_count, model_count);
        do_frame(4, 3, 0);

        for (int n = 0; n < 25; n++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 30));
            do_frame(d, ($urandom_range(0, 1) != 0) ? 3 : 0, int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inference_scheduler.md
INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 Parameter NUM_INPUTS, 10, number of fixed-point input words per frame.
REQ-002 Parameter NUM_OUTPUTS, 10, number of network output words; SHALL be >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, 4096, maximum cycles from net_start to net_done.
REQ-004 Words SHALL be signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] from the shared include.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  host frame valid.
REQ-008 in_ready  out  1  scheduler can accept a frame.
REQ-009 in_data  in  word[NUM_INPUTS]  host frame.
REQ-010 net_start  out  1  one-cycle start pulse to the network's inputs_ready.
REQ-011 net_inputs  out  word[NUM_INPUTS]  registered frame to the network.
REQ-012 net_done  in  1  network outputs_ready.
REQ-013 net_outputs  in  word[NUM_OUTPUTS]  network outputs.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_data  out  word[NUM_OUTPUTS]  latched network outputs.
REQ-017 out_class  out  $clog2(NUM_OUTPUTS)  argmax index of out_data.
REQ-018 timeout_error  out  1  sticky watchdog flag.
REQ-019 error_clear  in  1  clears timeout_error.
REQ-020 frame_count  out  16  completed-result counter.

Function
REQ-021 FSM states SHALL be IDLE, START, WAIT, ARGMAX, PRESENT.
REQ-022 IDLE: in_ready=1; on in_valid, capture in_data into net_inputs register, go START.
REQ-023 in_ready SHALL be 0 in every state other than IDLE; in_valid outside IDLE is ignored.
REQ-024 START: net_start=1 for exactly this one cycle, watchdog counter cleared, go WAIT.
REQ-025 net_inputs SHALL hold stable from capture until the next IDLE accept.
REQ-026 WAIT: counter increments per cycle; on net_done, latch net_outputs into out_data, set best_idx=0, best_val=net_outputs[0], scan index=1, go ARGMAX.
REQ-027 WAIT: if counter reaches TIMEOUT_CYCLES-1 without net_done, set timeout_error, go IDLE, no result produced.
REQ-028 net_done and timeout expiry in the same cycle: net_done wins, timeout_error not set.
REQ-029 net_done outside WAIT SHALL be ignored.
REQ-030 ARGMAX: one element per cycle, signed compare out_data[i] > best_val updates best; ties keep lower index; after i=NUM_OUTPUTS-1 go PRESENT.
REQ-031 ARGMAX SHALL last NUM_OUTPUTS-1 cycles; with net_done at cycle D, out_valid first high at D+NUM_OUTPUTS.
REQ-032 PRESENT: out_valid=1, out_data and out_class stable until out_ready; on out_ready go IDLE and increment frame_count.
REQ-033 Accept at cycle T SHALL give net_start at T+1.
REQ-034 frame_count SHALL wrap 0xFFFF -> 0x0000.
REQ-035 timeout_error cleared only by reset or error_clear; set and clear in same cycle: set wins.

Reset
REQ-036 Reset SHALL force IDLE, net_start=0, out_valid=0, out_class=0, out_data=0, net_inputs=0, timeout_error=0, frame_count=0, counter=0.
REQ-037 Reset mid-operation (any state) SHALL abandon the frame; no out_valid until a new frame completes.

Verification
REQ-038 Frame accepted cycle 5, net_done 20 cycles later, outputs {0,..,0,3.5 at idx 7,..} -> net_start at cycle 6, out_valid at D+10, out_class=7, frame_count=1.
REQ-039 Outputs with equal maxima at idx 2 and 6, all others negative -> out_class=2.
REQ-040 TIMEOUT_CYCLES=64, net_done never asserted -> timeout_error=1 after 64 WAIT cycles, back in IDLE, in_ready=1, out_valid never high; error_clear -> 0.
REQ-041 out_ready held 0 for 15 cycles in PRESENT with in_valid=1 -> out_data/out_class stable, in_ready=0, no new net_start.
REQ-042 Reset asserted during ARGMAX -> next cycle IDLE, out_valid=0, frame_count=0.
REQ-043 frame_count preset to 0xFFFF via 65535 frames (or forced) plus one frame -> 0x0000.
